// File: rtl/dp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// dp_fifo_ctrl : single-clock FIFO controller driving a 16x4+parity EBR RAM.
// Optional parity generation/check enabled by macro DP_FIFO_PARITY_EN.
// Revision 1.0
// ============================================================================
module dp_fifo_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Push,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Pop,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DoutValid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  ParityErr,
  output logic [ADDR_WIDTH-1:0] RamWrAddress,
  output logic [ADDR_WIDTH-1:0] RamRdAddress,
  output logic [DATA_WIDTH-1:0] RamData,
  output logic                  RamEdi,
  output logic                  RamWrEn,
  output logic                  RamRdEn,
  input  logic [DATA_WIDTH-1:0] RamQ,
  input  logic                  RamEdo
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF     = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR1 = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_ok, rd_ok;

  // Acceptance uses the current-cycle flags only, so a pop never frees
  // room for a same-cycle push and a push never feeds a same-cycle pop.
  always_comb begin
    full  = (count_q == C_DEPTH);
    empty = (count_q == '0);
    wr_ok = Push & ~full;
    rd_ok = Pop & ~empty;

    wptr_d       = wr_ok ? wptr_q + C_PTR1 : wptr_q;
    rptr_d       = rd_ok ? rptr_q + C_PTR1 : rptr_q;
    count_d      = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
    dout_valid_d = rd_ok;
    overflow_d   = Push & full;
    underflow_d  = Pop & empty;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign RamWrEn      = wr_ok;
  assign RamRdEn      = rd_ok;
  assign RamData      = DataIn;
  assign RamWrAddress = wptr_q;
  assign RamRdAddress = rptr_q;

  assign DataOut    = RamQ;
  assign DoutValid  = dout_valid_q;
  assign Full       = full;
  assign Empty      = empty;
  assign AlmostFull = (count_q >= C_AF);
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign Underflow  = underflow_q;

`ifdef DP_FIFO_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Even parity: the stored bit makes the 5-bit word XOR to zero.
  always_comb begin
    parity_err_d = dout_valid_q & ((^RamQ) != RamEdo);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign RamEdi    = ^DataIn;
  assign ParityErr = parity_err_q;
`else
  logic unused_edo;
  assign unused_edo = RamEdo;
  assign RamEdi     = 1'b0;
  assign ParityErr  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dp_fifo_ctrl : self-checking bench for dp_fifo_ctrl with a behavioural
// RAM and a queue-based FIFO reference model.  Revision 1.0
// ============================================================================
module tb_dp_fifo_ctrl;

`ifdef DP_FIFO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, flip;
  logic [3:0] din;
  logic [3:0] dout, ram_wr_addr, ram_rd_addr, ram_data, ram_q;
  logic [4:0] count;
  logic       dv, full, empty, af, ovf, udf, perr;
  logic       ram_edi, ram_wr_en, ram_rd_en, ram_edo, ram_p;

  always #5 clk = ~clk;

  dp_fifo_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
    .Clock(clk), .ResetN(rst_n), .Push(push), .DataIn(din), .Pop(pop),
    .DataOut(dout), .DoutValid(dv), .Full(full), .Empty(empty),
    .AlmostFull(af), .Count(count), .Overflow(ovf), .Underflow(udf),
    .ParityErr(perr), .RamWrAddress(ram_wr_addr), .RamRdAddress(ram_rd_addr),
    .RamData(ram_data), .RamEdi(ram_edi), .RamWrEn(ram_wr_en),
    .RamRdEn(ram_rd_en), .RamQ(ram_q), .RamEdo(ram_edo)
  );

  // Behavioural dual-port RAM with registered read data and a parity bit.
  logic [3:0] mem_d [16];
  logic       mem_p [16];
  always_ff @(posedge clk) begin
    if (ram_wr_en) begin
      mem_d[ram_wr_addr] <= ram_data;
      mem_p[ram_wr_addr] <= ram_edi;
    end
    if (ram_rd_en) begin
      ram_q <= mem_d[ram_rd_addr];
      ram_p <= mem_p[ram_rd_addr];
    end
  end
  assign ram_edo = ram_p ^ flip;

  int         checks = 0;
  int         errors = 0;
  int         q[$];
  bit         exp_dv, exp_ovf, exp_udf, exp_perr;
  logic [3:0] exp_dout;

  typedef struct {
    bit         push;
    logic [3:0] din;
    bit         pop;
    int         cnt;
    bit         empty;
    bit         dv;
    logic [3:0] dout;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("almost_full", 32'(af), 32'(q.size() >= 12));
    chk("dout_valid", 32'(dv), 32'(exp_dv));
    if (exp_dv) chk("data_out", 32'(dout), 32'(exp_dout));
    chk("overflow", 32'(ovf), 32'(exp_ovf));
    chk("underflow", 32'(udf), 32'(exp_udf));
    chk("parity_err", 32'(perr), 32'(exp_perr));
  endtask

  // Called #1 after a rising edge; applies one cycle of stimulus.
  task automatic cycle(input bit p, input logic [3:0] d, input bit r, input bit f);
    bit wr, rd;
    int n;
    push = p; din = d; pop = r; flip = f;
    n  = q.size();
    wr = p && (n < 16);
    rd = r && (n > 0);
    #1;
    chk("ram_wr_en", 32'(ram_wr_en), 32'(wr));
    chk("ram_rd_en", 32'(ram_rd_en), 32'(rd));
    if (wr) chk("ram_data", 32'(ram_data), 32'(d));
    chk("ram_edi", 32'(ram_edi), PAR ? 32'(^d) : 32'd0);
    @(posedge clk);
    exp_perr = PAR && exp_dv && f;
    exp_dv   = rd;
    if (rd) exp_dout = 4'(q.pop_front());
    if (wr) q.push_back(int'(d));
    exp_ovf = p && (n == 16);
    exp_udf = r && (n == 0);
    #1;
    check_state();
  endtask

  task automatic clear_model();
    q.delete();
    exp_dv = 0; exp_ovf = 0; exp_udf = 0; exp_perr = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hA, 1'b0, 1, 1'b0, 1'b0, 4'h0};
    vecs[1] = '{1'b1, 4'h5, 1'b0, 2, 1'b0, 1'b0, 4'h0};
    vecs[2] = '{1'b1, 4'h3, 1'b0, 3, 1'b0, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 4'h0, 1'b1, 2, 1'b0, 1'b1, 4'hA};
    vecs[4] = '{1'b0, 4'h0, 1'b1, 1, 1'b0, 1'b1, 4'h5};
    vecs[5] = '{1'b0, 4'h0, 1'b1, 0, 1'b1, 1'b1, 4'h3};
    vecs[6] = '{1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 4'h0};

    rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = 4'h0; flip = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_state();
    chk("reset_ram_wr_en", 32'(ram_wr_en), 32'd0);
    chk("reset_ram_rd_en", 32'(ram_rd_en), 32'd0);
    @(posedge clk); #1;

    // Basic ordering from the vector table.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].push, vecs[i].din, vecs[i].pop, 1'b0);
      chk("vec_count", 32'(count), 32'(vecs[i].cnt));
      chk("vec_empty", 32'(empty), 32'(vecs[i].empty));
      chk("vec_dv", 32'(dv), 32'(vecs[i].dv));
      if (vecs[i].dv) chk("vec_dout", 32'(dout), 32'(vecs[i].dout));
    end

    // Fill to full, then push+pop while full: push must be dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    chk("full_at_16", 32'(full), 32'd1);
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("count_15", 32'(count), 32'd15);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Pop+push on empty: pop rejected, word readable next cycle.
    cycle(1'b1, 4'h9, 1'b1, 1'b0);
    chk("udf_pulse", 32'(udf), 32'd1);
    chk("count_1", 32'(count), 32'd1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("pop_9", 32'(dout), 32'h9);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Pointer wrap with steady occupancy of 8.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'($urandom), 1'b1, 1'b0);
    chk("wrap_count", 32'(count), 32'd8);
    for (int i = 0; i < 9; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);

    // Random traffic: first push-biased, then pop-biased.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i < 300) ? 70 : 35;
      cycle($urandom_range(0, 99) < bias, 4'($urandom),
            $urandom_range(0, 99) < (100 - bias), 1'b0);
    end
    while (q.size() > 0) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Corrupted parity on the returned word 6.
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    chk("perr_pulse", 32'(perr), PAR ? 32'd1 : 32'd0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    chk("perr_clear", 32'(perr), 32'd0);

    // Asynchronous reset mid-burst with Count=5 and DoutValid high.
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("pre_reset_dv", 32'(dv), 32'd1);
    chk("pre_reset_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0; push = 1'b0; pop = 1'b1;
    clear_model();
    #1;
    check_state();
    @(posedge clk); #1;
    check_state();
    pop = 1'b0;
    rst_n = 1'b1;
    #1;
    check_state();
    @(posedge clk); #1;
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_reset_c", 32'(dout), 32'hC);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
